// File: rtl/gs_pkg.sv
// Shared constants and the saturating clamp for the Gram-Schmidt column-update datapath.
package gs_pkg;

  localparam int unsigned GS_W    = 16;
  localparam int unsigned GS_FRAC = 10;
  localparam int unsigned GS_N    = 4;

  localparam logic signed [GS_W-1:0] ONE_FX  = GS_W'(1 << GS_FRAC);
  localparam logic signed [GS_W-1:0] SAT_MAX = {1'b0, {(GS_W-1){1'b1}}};
  localparam logic signed [GS_W-1:0] SAT_MIN = {1'b1, {(GS_W-1){1'b0}}};

  localparam logic signed [2*GS_W-1:0] SAT_MAX_2W = {{GS_W{1'b0}}, SAT_MAX};
  localparam logic signed [2*GS_W-1:0] SAT_MIN_2W = {{GS_W{1'b1}}, SAT_MIN};

  // Clamp a double-width signed value into the element range.
  function automatic logic [GS_W-1:0] sat_w(input logic signed [2*GS_W-1:0] x);
    if (x > SAT_MAX_2W)      sat_w = SAT_MAX;
    else if (x < SAT_MIN_2W) sat_w = SAT_MIN;
    else                     sat_w = x[GS_W-1:0];
  endfunction

endpackage

// File: rtl/gs_lane_mac.sv
// One lane of aj' = aj - rij*qi: multiply, round, subtract+saturate, each in its own stage.
module gs_lane_mac
  import gs_pkg::*;
#(
  parameter int unsigned W    = GS_W,
  parameter int unsigned FRAC = GS_FRAC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en1,
  input  logic         en2,
  input  logic         en3,
  input  logic [W-1:0] rij,
  input  logic [W-1:0] qi,
  input  logic [W-1:0] aj,
  output logic [W-1:0] d,
  output logic         sat_c
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned RW = PW - FRAC;
  localparam logic signed [PW-1:0] RND = PW'(1) << (FRAC - 1);

  logic signed [PW-1:0] p_q, p_d;
  logic signed [RW-1:0] r_q, r_d;
  logic [W-1:0] aj1_q, aj1_d, aj2_q, aj2_d;
  logic [W-1:0] d_q, d_d;
  logic signed [PW-1:0] p_rnd;
  logic signed [PW-1:0] diff;
  logic [W-1:0] d_sat;

  always_comb begin
    p_d   = p_q;
    r_d   = r_q;
    aj1_d = aj1_q;
    aj2_d = aj2_q;
    d_d   = d_q;
    p_rnd = p_q + RND;
    diff  = PW'($signed(aj2_q)) - PW'(r_q);
    // Result fits W bits only if the bits above the sign are all copies of it.
    sat_c = (diff[PW-1:W-1] != {(W+1){diff[PW-1]}});
    if (en1) begin
      p_d   = PW'($signed(rij)) * PW'($signed(qi));
      aj1_d = aj;
    end
    if (en2) begin
      r_d   = p_rnd[PW-1:FRAC];
      aj2_d = aj1_q;
    end
    if (en3) d_d = d_sat;
  end

  if (W == GS_W) begin : g_pkg_sat
    assign d_sat = sat_w(diff);
  end else begin : g_gen_sat
    assign d_sat = sat_c ? {diff[PW-1], {(W-1){~diff[PW-1]}}} : diff[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      r_q   <= '0;
      aj1_q <= '0;
      aj2_q <= '0;
      d_q   <= '0;
    end else begin
      p_q   <= p_d;
      r_q   <= r_d;
      aj1_q <= aj1_d;
      aj2_q <= aj2_d;
      d_q   <= d_d;
    end
  end

  assign d = d_q;

endmodule

// File: rtl/gs_column_update.sv
// Gram-Schmidt column update: N lanes of aj - rij*qi with a 3-stage valid/ready pipeline.
module gs_column_update
  import gs_pkg::*;
#(
  parameter int unsigned W    = GS_W,
  parameter int unsigned FRAC = GS_FRAC,
  parameter int unsigned N    = GS_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_rij,
  input  logic [N*W-1:0] in_qi,
  input  logic [N*W-1:0] in_aj,
  input  logic           in_last,
  input  logic           clr_sat,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_aj,
  output logic           out_last,
  output logic           sat_flag
);

  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic last1_q, last1_d, last2_q, last2_d, last3_q, last3_d;
  logic sat_q, sat_d;
  logic load1, load2, load3;
  logic [N-1:0] lane_sat;

  // Back-pressure ripples from out_ready to in_ready with no skid storage.
  always_comb begin
    load3    = v2_q && (!v3_q || out_ready);
    load2    = v1_q && (!v2_q || load3);
    in_ready = !v1_q || load2;
    load1    = in_valid && in_ready;

    v1_d    = load1 ? 1'b1 : (load2 ? 1'b0 : v1_q);
    v2_d    = load2 ? 1'b1 : (load3 ? 1'b0 : v2_q);
    v3_d    = load3 ? 1'b1 : (out_ready ? 1'b0 : v3_q);
    last1_d = load1 ? in_last : last1_q;
    last2_d = load2 ? last1_q : last2_q;
    last3_d = load3 ? last2_q : last3_q;

    sat_d = sat_q;
    if (load3 && (|lane_sat)) sat_d = 1'b1;
    else if (clr_sat)         sat_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
      last3_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      last1_q <= last1_d;
      last2_q <= last2_d;
      last3_q <= last3_d;
      sat_q   <= sat_d;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    gs_lane_mac #(.W(W), .FRAC(FRAC)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en1   (load1),
      .en2   (load2),
      .en3   (load3),
      .rij   (in_rij),
      .qi    (in_qi[k*W +: W]),
      .aj    (in_aj[k*W +: W]),
      .d     (out_aj[k*W +: W]),
      .sat_c (lane_sat[k])
    );
  end

  assign out_valid = v3_q;
  assign out_last  = last3_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_gs_column_update.sv
// Directed bench for gs_column_update: vector table, streaming with stalls, reset flush.
module tb_gs_column_update;
  import gs_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned N  = 4;
  localparam int unsigned NW = N * W;

  typedef struct {
    logic [W-1:0]  rij;
    logic [NW-1:0] qi;
    logic [NW-1:0] aj;
    logic [NW-1:0] exp_aj;
    logic          exp_sat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, in_last, clr_sat, out_valid, out_ready, out_last, sat_flag;
  logic [W-1:0]  in_rij;
  logic [NW-1:0] in_qi, in_aj, out_aj;

  gs_column_update dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rij(in_rij), .in_qi(in_qi), .in_aj(in_aj), .in_last(in_last),
    .clr_sat(clr_sat), .out_valid(out_valid), .out_ready(out_ready),
    .out_aj(out_aj), .out_last(out_last), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  vec_t vt[9];

  logic [NW:0] exp_q[$];
  int n_sent, n_recv, send_limit;
  logic hold_pend;
  logic [NW:0] hold_val;

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [NW-1:0] beat_aj(input int b);
    logic [NW-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = 16'(16'h0200 + b * 16 + k);
    return r;
  endfunction

  // With rij = 1.0 and qi = 0.25 every lane loses exactly 0x0100.
  function automatic logic [NW-1:0] beat_exp(input int b);
    logic [NW-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = 16'(16'h0100 + b * 16 + k);
    return r;
  endfunction

  task automatic step(input logic ordy);
    logic [NW:0] e;
    @(negedge clk);
    if (hold_pend) check("stall_hold", {out_valid, out_last, out_aj}, {1'b1, hold_val});
    out_ready = ordy;
    in_valid  = (n_sent < send_limit);
    in_rij    = 16'h0400;
    in_qi     = {N{16'h0100}};
    in_aj     = beat_aj(n_sent);
    in_last   = ((n_sent % 4) == 3);
    #1;
    hold_pend = out_valid && !out_ready;
    hold_val  = {out_last, out_aj};
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_beat", {out_last, out_aj}, '0);
      else begin
        e = exp_q.pop_front();
        check("stream_beat", {out_last, out_aj}, e);
      end
      n_recv++;
    end
    if (in_valid && in_ready) begin
      exp_q.push_back({in_last, beat_exp(n_sent)});
      n_sent++;
    end
  endtask

  task automatic apply_vec(input vec_t v, input logic exp_sat, input int idx);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_rij    = v.rij;
    in_qi     = v.qi;
    in_aj     = v.aj;
    in_last   = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency[%0d]", idx), lat, 3);
    check($sformatf("out_aj[%0d]", idx), out_aj, v.exp_aj);
    check($sformatf("sat_flag[%0d]", idx), sat_flag, exp_sat);
    if (exp_sat) begin
      clr_sat = 1'b1;
      @(negedge clk);
      clr_sat = 1'b0;
      check($sformatf("sat_clr[%0d]", idx), sat_flag, 0);
    end
  endtask

  initial begin
    int cyc, cnt;
    vt[0] = '{ONE_FX, {4{16'h0200}}, {4{16'h0C00}}, {4{16'h0A00}}, 1'b0};
    vt[1] = '{16'h0001, 64'h01FF_0200_01FF_0200, 64'h0, 64'h0000_FFFF_0000_FFFF, 1'b0};
    vt[2] = '{16'hF000, {4{16'h7FFF}}, {4{16'h7000}}, {4{16'h7FFF}}, 1'b1};
    vt[3] = '{16'h1000, {4{16'h7FFF}}, {4{16'h8000}}, {4{16'h8000}}, 1'b1};
    vt[4] = '{16'h0000, 64'h7FFF_8000_0001_FFFF, 64'h1234_8000_7FFF_ABCD, 64'h1234_8000_7FFF_ABCD, 1'b0};
    vt[5] = '{16'h7FFF, 64'h0, 64'h0001_FFFF_5555_AAAA, 64'h0001_FFFF_5555_AAAA, 1'b0};
    vt[6] = '{16'h8000, {4{16'h8000}}, 64'h0, {4{16'h8000}}, 1'b1};
    vt[7] = '{16'h0400, 64'h0000_0100_FC00_0400, {4{16'h0100}}, 64'h0100_0000_0500_FD00, 1'b0};
    vt[8] = '{16'hFFFF, 64'h0201_0200_0201_0200, {4{16'h0005}}, 64'h0006_0005_0006_0005, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_rij = '0; in_qi = '0; in_aj = '0;
    in_last = 1'b0; clr_sat = 1'b0; out_ready = 1'b1;
    hold_pend = 1'b0; n_sent = 0; n_recv = 0; send_limit = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_aj", out_aj, 0);
    check("rst_out_last", out_last, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 9; i++) apply_vec(vt[i], vt[i].exp_sat, i);

    // Saturating beat reaches S3 in the same cycle clr_sat is high: set must win.
    @(negedge clk);
    in_valid = 1'b1; in_rij = vt[2].rij; in_qi = vt[2].qi; in_aj = vt[2].aj;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    clr_sat = 1'b1;
    @(negedge clk);
    clr_sat = 1'b0;
    check("set_wins_valid", out_valid, 1);
    check("set_wins_flag", sat_flag, 1);
    apply_vec(vt[0], 1'b1, 100);

    // Eight back-to-back beats against a toggling out_ready.
    exp_q.delete(); n_sent = 0; n_recv = 0; send_limit = 8; hold_pend = 1'b0;
    for (cyc = 0; cyc < 100 && n_recv < 8; cyc++) step(cyc % 2 == 0);
    check("stream_count", n_recv, 8);
    check("stream_sent", n_sent, 8);

    // Full stall: only three beats fit, then the stage drains one per cycle.
    exp_q.delete(); n_sent = 0; n_recv = 0; send_limit = 10; hold_pend = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b0);
    check("stall_accepted", n_sent, 3);
    check("stall_in_ready", in_ready, 0);
    send_limit = n_sent;
    cyc = 0;
    while (n_recv < 3 && cyc < 20) begin
      step(1'b1);
      cyc++;
    end
    check("drain_cycles", cyc, 3);
    check("drain_count", n_recv, 3);
    @(negedge clk);
    in_valid = 1'b0;

    // Reset with beats in flight flushes them.
    out_ready = 1'b0;
    in_rij = '0; in_qi = '0;
    in_valid = 1'b1; in_aj = beat_aj(1);
    @(negedge clk);
    in_aj = beat_aj(2);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_aj", out_aj, beat_aj(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_aj", out_aj, 0);
    check("mid_rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("post_rst_stale", cnt, 0);
    check("post_rst_in_ready", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
